// File: rtl/mole_round_if.sv
// Bundle between the game-state FSM (master) and the per-round engine (slave).
// Strobes (tick, clear, hit_miss, round_done) are single-cycle pulses with no back-pressure; levels hold until changed.
interface mole_round_if #(
    parameter int N_HOLES = 4,
    parameter int SCORE_W = 8
);
    logic               tick;
    logic               clear;
    logic               game_en;
    logic [N_HOLES-1:0] buttons;
    logic [N_HOLES-1:0] mole_onehot;
    logic [1:0]         hit_miss;
    logic               round_done;
    logic               timer_expired;
    logic [SCORE_W-1:0] hit_count;
    logic [SCORE_W-1:0] miss_count;
    logic [2:0]         state_dbg;

    modport master (
        output tick, clear, game_en, buttons,
        input  mole_onehot, hit_miss, round_done, timer_expired, hit_count, miss_count, state_dbg
    );

    modport slave (
        input  tick, clear, game_en, buttons,
        output mole_onehot, hit_miss, round_done, timer_expired, hit_count, miss_count, state_dbg
    );
endinterface

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round engine: picks a hole from an LFSR, times the mole window, classifies presses,
// paces rounds with a pause and owns the overall game timer and score counters.
module mole_round_ctrl #(
    parameter int         N_HOLES     = 4,
    parameter int         MOLE_TICKS  = 750,
    parameter int         PAUSE_TICKS = 250,
    parameter int         GAME_TICKS  = 30000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         SCORE_W     = 8
) (
    input logic         clk,
    input logic         reset,
    mole_round_if.slave bus
);
    localparam int HW = $clog2(N_HOLES);
    localparam int MW = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
    localparam int PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam int GW = $clog2(GAME_TICKS + 1);
    localparam logic [MW-1:0]      MOLE_LAST  = MW'(MOLE_TICKS - 1);
    localparam logic [PW-1:0]      PAUSE_LAST = PW'(PAUSE_TICKS - 1);
    localparam logic [GW-1:0]      GAME_LAST  = GW'(GAME_TICKS - 1);
    localparam logic [N_HOLES-1:0] HOLE0      = N_HOLES'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_UP    = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [HW-1:0]      prev_hole_q, prev_hole_d;
    logic [N_HOLES-1:0] btn_prev_q, btn_prev_d;
    logic [MW-1:0]      mole_cnt_q, mole_cnt_d;
    logic [PW-1:0]      pause_cnt_q, pause_cnt_d;
    logic [GW-1:0]      game_tmr_q, game_tmr_d;
    logic [N_HOLES-1:0] mole_onehot_q, mole_onehot_d;
    logic [1:0]         hit_miss_q, hit_miss_d;
    logic               round_done_q, round_done_d;
    logic               timer_expired_q, timer_expired_d;
    logic [SCORE_W-1:0] hit_count_q, hit_count_d;
    logic [SCORE_W-1:0] miss_count_q, miss_count_d;

    logic [N_HOLES-1:0] press;
    logic [HW-1:0]      spawn_hole;
    logic               expire;

    always_comb begin
        press      = bus.buttons & ~btn_prev_q;
        spawn_hole = lfsr_q[HW-1:0];
        // Never light the same hole twice in a row.
        if (spawn_hole == prev_hole_q) begin
            spawn_hole = spawn_hole + HW'(1);
        end
        expire = (state_q == S_SPAWN || state_q == S_UP || state_q == S_PAUSE) &&
                 bus.tick && (game_tmr_q == GAME_LAST);

        state_d         = state_q;
        lfsr_d          = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        prev_hole_d     = prev_hole_q;
        btn_prev_d      = bus.buttons;
        mole_cnt_d      = mole_cnt_q;
        pause_cnt_d     = pause_cnt_q;
        game_tmr_d      = game_tmr_q;
        mole_onehot_d   = mole_onehot_q;
        hit_miss_d      = 2'b00;
        round_done_d    = 1'b0;
        timer_expired_d = timer_expired_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;

        if (bus.clear) begin
            state_d         = S_IDLE;
            mole_cnt_d      = '0;
            pause_cnt_d     = '0;
            game_tmr_d      = '0;
            mole_onehot_d   = '0;
            timer_expired_d = 1'b0;
            hit_count_d     = '0;
            miss_count_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    mole_onehot_d = '0;
                    if (bus.game_en && !timer_expired_q) begin
                        state_d = S_SPAWN;
                    end
                end
                S_DONE: begin
                    mole_onehot_d = '0;
                end
                default: begin
                    // Dropping game_en parks the round; timer and scores are kept for resume.
                    if (!bus.game_en) begin
                        state_d       = S_IDLE;
                        mole_onehot_d = '0;
                    end else if (expire) begin
                        game_tmr_d      = game_tmr_q + GW'(1);
                        timer_expired_d = 1'b1;
                        state_d         = S_DONE;
                        mole_onehot_d   = '0;
                    end else begin
                        if (bus.tick) begin
                            game_tmr_d = game_tmr_q + GW'(1);
                        end
                        unique case (state_q)
                            S_SPAWN: begin
                                prev_hole_d   = spawn_hole;
                                mole_onehot_d = HOLE0 << spawn_hole;
                                mole_cnt_d    = '0;
                                state_d       = S_UP;
                            end
                            S_UP: begin
                                if (press != '0 || (bus.tick && mole_cnt_q == MOLE_LAST)) begin
                                    mole_onehot_d = '0;
                                    pause_cnt_d   = '0;
                                    state_d       = S_PAUSE;
                                    if (press == mole_onehot_q) begin
                                        hit_miss_d = 2'b01;
                                        if (hit_count_q != '1) begin
                                            hit_count_d = hit_count_q + SCORE_W'(1);
                                        end
                                    end else begin
                                        hit_miss_d = 2'b10;
                                        if (miss_count_q != '1) begin
                                            miss_count_d = miss_count_q + SCORE_W'(1);
                                        end
                                    end
                                end else if (bus.tick) begin
                                    mole_cnt_d = mole_cnt_q + MW'(1);
                                end
                            end
                            S_PAUSE: begin
                                if (bus.tick) begin
                                    if (pause_cnt_q == PAUSE_LAST) begin
                                        round_done_d = 1'b1;
                                        state_d      = S_SPAWN;
                                    end else begin
                                        pause_cnt_d = pause_cnt_q + PW'(1);
                                    end
                                end
                            end
                            default: begin
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            lfsr_q          <= LFSR_SEED;
            prev_hole_q     <= '0;
            btn_prev_q      <= '0;
            mole_cnt_q      <= '0;
            pause_cnt_q     <= '0;
            game_tmr_q      <= '0;
            mole_onehot_q   <= '0;
            hit_miss_q      <= 2'b00;
            round_done_q    <= 1'b0;
            timer_expired_q <= 1'b0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            prev_hole_q     <= prev_hole_d;
            btn_prev_q      <= btn_prev_d;
            mole_cnt_q      <= mole_cnt_d;
            pause_cnt_q     <= pause_cnt_d;
            game_tmr_q      <= game_tmr_d;
            mole_onehot_q   <= mole_onehot_d;
            hit_miss_q      <= hit_miss_d;
            round_done_q    <= round_done_d;
            timer_expired_q <= timer_expired_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
        end
    end

    assign bus.mole_onehot   = mole_onehot_q;
    assign bus.hit_miss      = hit_miss_q;
    assign bus.round_done    = round_done_q;
    assign bus.timer_expired = timer_expired_q;
    assign bus.hit_count     = hit_count_q;
    assign bus.miss_count    = miss_count_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl with shortened timing: hit/miss codes go through an expected queue,
// the spawned hole is predicted from an independent LFSR model.
module tb_mole_round_ctrl;
    localparam int         N    = 4;
    localparam int         MT   = 8;
    localparam int         PT   = 5;
    localparam int         GT   = 47;
    localparam int         SW   = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mole_round_if #(.N_HOLES(N), .SCORE_W(SW)) bus ();

    mole_round_ctrl #(
        .N_HOLES(N), .MOLE_TICKS(MT), .PAUSE_TICKS(PT),
        .GAME_TICKS(GT), .LFSR_SEED(SEED), .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_exp;
    logic [7:0]  lfsr_m;
    logic [7:0]  lfsr_prev;
    logic [1:0]  m_prev_hole;
    logic [N-1:0] cur_mole;
    logic [N-1:0] last_mole;

    // Reference LFSR: taps 8,6,5,4, reloaded while reset is low.
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (!reset) lfsr_m <= SEED;
        else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    always @(negedge clk) begin
        if (bus.hit_miss !== 2'b00) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL hit_miss_unexpected: got %b, expected none", bus.hit_miss);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.hit_miss !== mon_exp) begin
                    n_errors++;
                    $display("FAIL hit_miss_code: got %b, expected %b", bus.hit_miss, mon_exp);
                end
            end
        end
    end

    task automatic wait_mole();
        int k = 0;
        logic [1:0] h;
        while (bus.mole_onehot === '0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        h = lfsr_prev[1:0];
        if (h == m_prev_hole) h = h + 2'd1;
        n_checks++;
        if (bus.mole_onehot !== (4'b0001 << h)) begin
            n_errors++;
            $display("FAIL mole_hole: got %b, expected %b", bus.mole_onehot, 4'b0001 << h);
        end
        m_prev_hole = h;
        last_mole   = cur_mole;
        cur_mole    = bus.mole_onehot;
    endtask

    task automatic press(input logic [N-1:0] mask, input logic [1:0] code, input logic with_tick,
                         input logic hold);
        if (code != 2'b00) exp_q.push_back(code);
        bus.buttons = mask;
        bus.tick    = with_tick;
        @(negedge clk);
        bus.tick = 1'b0;
        if (!hold) bus.buttons = '0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    task automatic do_pause();
        for (int i = 0; i < PT; i++) begin
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
            n_checks++;
            if (bus.round_done !== (i == PT - 1)) begin
                n_errors++;
                $display("FAIL round_done_tick%0d: got %b, expected %b", i, bus.round_done, i == PT - 1);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.round_done !== 1'b0) begin
            n_errors++;
            $display("FAIL round_done_width: got %b, expected 0", bus.round_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.buttons = '1; bus.tick = 1'b1; bus.game_en = 1'b0; bus.clear = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.mole_onehot, bus.hit_miss, bus.round_done, bus.timer_expired} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b, expected all 0",
                     bus.mole_onehot, bus.hit_miss, bus.round_done, bus.timer_expired);
        end
        n_checks++;
        if ({bus.hit_count, bus.miss_count, bus.state_dbg} !== '0) begin
            n_errors++;
            $display("FAIL reset_counts: got hit=%0d miss=%0d state=%0d, expected 0/0/0",
                     bus.hit_count, bus.miss_count, bus.state_dbg);
        end
        reset = 1'b1; bus.buttons = '0; bus.tick = 1'b0;
        m_prev_hole = 2'd0;
        @(negedge clk);
        n_checks++;
        if (bus.state_dbg !== 3'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got state %0d, expected 0", bus.state_dbg);
        end
    endtask

    task automatic test_hit();
        bus.game_en = 1'b1;
        wait_mole();
        press(cur_mole, 2'b01, 1'b0, 1'b0);
        n_checks++;
        if (bus.hit_count !== 2'd1 || bus.miss_count !== 2'd0 || bus.mole_onehot !== '0) begin
            n_errors++;
            $display("FAIL hit_counts: got hit=%0d miss=%0d mole=%b, expected 1/0/0000",
                     bus.hit_count, bus.miss_count, bus.mole_onehot);
        end
        do_pause();
    endtask

    task automatic test_misses();
        logic [N-1:0] wrong;
        wait_mole();
        n_checks++;
        if (cur_mole === last_mole) begin
            n_errors++;
            $display("FAIL hole_repeat: got %b, expected a different hole than %b", cur_mole, last_mole);
        end
        wrong = {cur_mole[N-2:0], cur_mole[N-1]};
        press(wrong, 2'b10, 1'b0, 1'b0);
        n_checks++;
        if (bus.miss_count !== 2'd1) begin
            n_errors++;
            $display("FAIL miss_wrong_hole: got %0d, expected 1", bus.miss_count);
        end
        do_pause();
        wait_mole();
        wrong = {cur_mole[N-2:0], cur_mole[N-1]};
        press(cur_mole | wrong, 2'b10, 1'b0, 1'b0);
        n_checks++;
        if (bus.miss_count !== 2'd2 || bus.hit_count !== 2'd1) begin
            n_errors++;
            $display("FAIL miss_multi_press: got miss=%0d hit=%0d, expected 2/1", bus.miss_count, bus.hit_count);
        end
        do_pause();
        wait_mole();
        ticks(MT - 1);
        n_checks++;
        if (bus.mole_onehot !== cur_mole) begin
            n_errors++;
            $display("FAIL mole_before_timeout: got %b, expected %b", bus.mole_onehot, cur_mole);
        end
        press('0, 2'b10, 1'b1, 1'b0);
        n_checks++;
        if (bus.miss_count !== 2'd3 || bus.mole_onehot !== '0) begin
            n_errors++;
            $display("FAIL miss_timeout: got miss=%0d mole=%b, expected 3/0000", bus.miss_count, bus.mole_onehot);
        end
        do_pause();
    endtask

    task automatic test_race_tick();
        wait_mole();
        ticks(MT - 1);
        press(cur_mole, 2'b01, 1'b1, 1'b0);
        n_checks++;
        if (bus.hit_count !== 2'd2 || bus.miss_count !== 2'd3) begin
            n_errors++;
            $display("FAIL race_last_tick: got hit=%0d miss=%0d, expected 2/3", bus.hit_count, bus.miss_count);
        end
        do_pause();
    endtask

    task automatic test_expiry();
        // 41 game ticks used so far; 5 more leave the next tick as the final one.
        wait_mole();
        ticks(GT - 42);
        n_checks++;
        if (bus.mole_onehot !== cur_mole || bus.timer_expired !== 1'b0) begin
            n_errors++;
            $display("FAIL pre_expiry: got mole=%b exp=%b, expected %b/0", bus.mole_onehot, bus.timer_expired, cur_mole);
        end
        press(cur_mole, 2'b00, 1'b1, 1'b0);
        n_checks++;
        if (bus.timer_expired !== 1'b1 || bus.mole_onehot !== '0 || bus.state_dbg !== 3'd4) begin
            n_errors++;
            $display("FAIL expiry: got exp=%b mole=%b state=%0d, expected 1/0000/4",
                     bus.timer_expired, bus.mole_onehot, bus.state_dbg);
        end
        n_checks++;
        if (bus.hit_count !== 2'd2 || bus.miss_count !== 2'd3) begin
            n_errors++;
            $display("FAIL expiry_counts: got hit=%0d miss=%0d, expected 2/3", bus.hit_count, bus.miss_count);
        end
        ticks(2);
        press('1, 2'b00, 1'b1, 1'b0);
        n_checks++;
        if (bus.state_dbg !== 3'd4 || bus.timer_expired !== 1'b1 || bus.round_done !== 1'b0 ||
            bus.mole_onehot !== '0) begin
            n_errors++;
            $display("FAIL done_sticky: got state=%0d exp=%b rd=%b mole=%b, expected 4/1/0/0000",
                     bus.state_dbg, bus.timer_expired, bus.round_done, bus.mole_onehot);
        end
    endtask

    task automatic test_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n_checks++;
        if (bus.timer_expired !== 1'b0 || bus.hit_count !== '0 || bus.miss_count !== '0 ||
            bus.state_dbg !== 3'd0) begin
            n_errors++;
            $display("FAIL clear_from_done: got exp=%b hit=%0d miss=%0d state=%0d, expected 0/0/0/0",
                     bus.timer_expired, bus.hit_count, bus.miss_count, bus.state_dbg);
        end
        wait_mole();
        press(cur_mole, 2'b01, 1'b0, 1'b0);
        do_pause();
        wait_mole();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n_checks++;
        if (bus.mole_onehot !== '0 || bus.hit_count !== '0 || bus.state_dbg !== 3'd0) begin
            n_errors++;
            $display("FAIL clear_mid_up: got mole=%b hit=%0d state=%0d, expected 0000/0/0",
                     bus.mole_onehot, bus.hit_count, bus.state_dbg);
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] held;
        wait_mole();
        held = cur_mole;
        press(cur_mole, 2'b01, 1'b0, 1'b1);
        do_pause();
        wait_mole();
        ticks(3);
        n_checks++;
        if (bus.hit_count !== 2'd1 || bus.miss_count !== 2'd0 || bus.mole_onehot !== cur_mole) begin
            n_errors++;
            $display("FAIL held_button: got hit=%0d miss=%0d mole=%b, expected 1/0/%b (held %b)",
                     bus.hit_count, bus.miss_count, bus.mole_onehot, cur_mole, held);
        end
        bus.buttons = '0;
        @(negedge clk);
        press(cur_mole, 2'b01, 1'b0, 1'b0);
        n_checks++;
        if (bus.hit_count !== 2'd2) begin
            n_errors++;
            $display("FAIL press_after_release: got %0d, expected 2", bus.hit_count);
        end
        do_pause();
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 3; r++) begin
            wait_mole();
            press(cur_mole, 2'b01, 1'b0, 1'b0);
            n_checks++;
            if (bus.hit_count !== 2'd3) begin
                n_errors++;
                $display("FAIL hit_saturate_%0d: got %0d, expected 3", r, bus.hit_count);
            end
            do_pause();
        end
    endtask

    task automatic test_reset_mid_pause();
        wait_mole();
        press(cur_mole, 2'b01, 1'b0, 1'b0);
        ticks(2);
        reset = 1'b0;
        bus.tick = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.mole_onehot, bus.hit_miss, bus.round_done, bus.hit_count, bus.state_dbg} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_pause: got mole=%b hm=%b rd=%b hit=%0d state=%0d, expected all 0",
                     bus.mole_onehot, bus.hit_miss, bus.round_done, bus.hit_count, bus.state_dbg);
        end
        reset = 1'b1;
        bus.tick = 1'b0;
        m_prev_hole = 2'd0;
        @(negedge clk);
        n_checks++;
        if (bus.round_done !== 1'b0 || bus.hit_count !== '0) begin
            n_errors++;
            $display("FAIL post_reset: got rd=%b hit=%0d, expected 0/0", bus.round_done, bus.hit_count);
        end
        wait_mole();
    endtask

    task automatic test_game_en_low();
        bus.game_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.state_dbg !== 3'd0 || bus.mole_onehot !== '0) begin
            n_errors++;
            $display("FAIL game_en_low: got state=%0d mole=%b, expected 0/0000", bus.state_dbg, bus.mole_onehot);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.tick = 1'b0; bus.clear = 1'b0; bus.game_en = 1'b0; bus.buttons = '0;
        cur_mole = '0; last_mole = '0; m_prev_hole = 2'd0;
        test_reset();
        test_hit();
        test_misses();
        test_race_tick();
        test_expiry();
        test_clear();
        test_hold();
        test_saturation();
        test_reset_mid_pause();
        test_game_en_low();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
